// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, flush, bubble masking and a saturating stall counter.
// Optional 2-entry skid buffer (registered in_ready) is enabled by defining PIPE_SKID_EN.
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int MEM_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [MEM_W-1:0]  mem_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [REG_W-1:0]  reg_dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [MEM_W-1:0]  mem_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] rt_out,
  output logic [REG_W-1:0]  reg_dest_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] rt;
    logic [REG_W-1:0]  reg_dest;
  } payload_t;

  payload_t   in_pl;
  payload_t   main_pl;
  logic       main_valid;
  logic       accept;
  logic       emit;

  assign in_pl  = {wb_in, mem_in, alu_res_in, rt_in, reg_dest_in};
  assign accept = in_valid && in_ready;
  assign emit   = main_valid && out_ready;

`ifdef PIPE_SKID_EN
  payload_t skid_pl;
  logic     skid_valid;

  // Registered ready: out_ready never reaches in_ready combinationally.
  assign in_ready = !skid_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_pl    <= '0;
      skid_valid <= 1'b0;
      skid_pl    <= '0;
    end else if (flush) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_pl.wb  <= '0;
      main_pl.mem <= '0;
      skid_pl.wb  <= '0;
      skid_pl.mem <= '0;
    end else if (emit) begin
      if (skid_valid) begin
        main_pl    <= skid_pl;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_pl    <= in_pl;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_pl    <= in_pl;
        skid_valid <= 1'b1;
      end else begin
        main_pl    <= in_pl;
        main_valid <= 1'b1;
      end
    end
  end
`else
  assign in_ready = !main_valid || out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_pl    <= '0;
    end else if (flush) begin
      main_valid  <= 1'b0;
      main_pl.wb  <= '0;
      main_pl.mem <= '0;
    end else if (accept) begin
      main_pl    <= in_pl;
      main_valid <= 1'b1;
    end else if (emit) begin
      main_valid <= 1'b0;
    end
  end
`endif

  // Counts stalled cycles regardless of flush; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid    = main_valid;
  assign wb_out       = main_pl.wb  & {WB_W{main_valid}};
  assign mem_out      = main_pl.mem & {MEM_W{main_valid}};
  assign alu_res_out  = main_pl.alu_res;
  assign rt_out       = main_pl.rt;
  assign reg_dest_out = main_pl.reg_dest;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Self-checking bench for exe_mem_pipe_reg: directed steps then random traffic against a queue-based model.
// Honours PIPE_SKID_EN to match the DUT build.
module tb_exe_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int WB_W   = 2;
  localparam int MEM_W  = 2;
  localparam int CNT_W  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic [REG_W-1:0]  dest;
  } pl_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WB_W-1:0]   wb_in, wb_out;
  logic [MEM_W-1:0]  mem_in, mem_out;
  logic [DATA_W-1:0] alu_res_in, alu_res_out, rt_in, rt_out;
  logic [REG_W-1:0]  reg_dest_in, reg_dest_out;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  pl_t q[$];
  pl_t disp;
  int  cnt;

  always #5 clk = ~clk;

  exe_mem_pipe_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W), .MEM_W(MEM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_in(wb_in), .mem_in(mem_in), .alu_res_in(alu_res_in),
    .rt_in(rt_in), .reg_dest_in(reg_dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_out(wb_out), .mem_out(mem_out), .alu_res_out(alu_res_out),
    .rt_out(rt_out), .reg_dest_out(reg_dest_out),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic ordy);
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  function automatic pl_t mk(input logic [1:0] wb, input logic [1:0] mem, input logic [31:0] alu);
    pl_t p;
    p.wb = wb; p.mem = mem; p.alu = alu; p.rt = ~alu; p.dest = alu[4:0] ^ 5'h15;
    return p;
  endfunction

  function automatic pl_t rand_pl();
    pl_t p;
    p.wb = 2'($urandom); p.mem = 2'($urandom);
    p.alu = $urandom; p.rt = $urandom; p.dest = 5'($urandom);
    return p;
  endfunction

  task automatic check_outputs();
    logic v;
    v = q.size() > 0;
    check("out_valid", out_valid, v);
    check("wb_out", wb_out, v ? q[0].wb : '0);
    check("mem_out", mem_out, v ? q[0].mem : '0);
    check("alu_res_out", alu_res_out, disp.alu);
    check("rt_out", rt_out, disp.rt);
    check("reg_dest_out", reg_dest_out, disp.dest);
    check("stall_cnt", stall_cnt, cnt);
  endtask

  // One clock: drive at posedge+1, check in_ready, then advance model with the edge and check outputs.
  task automatic step(input logic v, input logic ordy, input logic fl, input logic r, input pl_t p);
    logic rdy, acc, emit;
    in_valid = v; out_ready = ordy; flush = fl; rst = r;
    wb_in = p.wb; mem_in = p.mem; alu_res_in = p.alu; rt_in = p.rt; reg_dest_in = p.dest;
    #1;
    rdy = model_ready(ordy);
    check("in_ready", in_ready, rdy);
    @(posedge clk);
    if (r) begin
      q.delete(); disp = '0; cnt = 0;
    end else begin
      if (q.size() > 0 && !ordy && cnt < CNT_MAX) cnt++;
      if (fl) begin
        q.delete();
      end else begin
        emit = (q.size() > 0) && ordy;
        acc  = v && rdy;
        if (emit) void'(q.pop_front());
        if (acc) q.push_back(p);
        if (q.size() > 0) disp = q[0];
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    pl_t z;
    z = '0;
    q.delete(); disp = '0; cnt = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_in = '0; mem_in = '0; alu_res_in = '0; rt_in = '0; reg_dest_in = '0;
    @(posedge clk); #1;

    // Reset then stream 0x10, 0x20, 0x30.
    step(0, 1, 0, 1, z);
    step(0, 1, 0, 1, z);
    step(1, 1, 0, 0, mk(2'b10, 2'b00, 32'h10));
    check("stream_first", alu_res_out, 32'h10);
    step(1, 1, 0, 0, mk(2'b10, 2'b00, 32'h20));
    step(1, 1, 0, 0, mk(2'b10, 2'b00, 32'h30));
    check("stream_third", alu_res_out, 32'h30);
    check("stream_valid", out_valid, 1'b1);
    step(0, 1, 0, 0, z);
    check("stream_cnt", stall_cnt, 0);

    // Back-pressure on 0xAA with 0xBB pending.
    step(1, 1, 0, 0, mk(2'b01, 2'b10, 32'hAA));
    repeat (4) step(1, 0, 0, 0, mk(2'b11, 2'b01, 32'hBB));
    check("bp_hold", alu_res_out, 32'hAA);
    check("bp_cnt", stall_cnt, 4);
    check("bp_in_ready", in_ready, 1'b0);
    step(0, 1, 0, 0, z);
    step(0, 1, 0, 0, z);
    step(0, 1, 0, 0, z);

    // Flush kills held entry and simultaneous accept.
    step(1, 0, 0, 0, mk(2'b11, 2'b01, 32'h55));
    step(1, 0, 1, 0, mk(2'b11, 2'b11, 32'h66));
    check("flush_valid", out_valid, 1'b0);
    check("flush_wb", wb_out, 2'b00);
    check("flush_mem", mem_out, 2'b00);
    step(0, 1, 0, 0, z);
    check("flush_ready", in_ready, 1'b1);

    // Bubble mid-stream.
    step(1, 1, 0, 0, mk(2'b11, 2'b11, 32'h100));
    step(0, 1, 0, 0, z);
    check("bubble_alu", alu_res_out, 32'h100);
    check("bubble_wb", wb_out, 2'b00);
    step(1, 1, 0, 0, mk(2'b11, 2'b10, 32'h200));
    step(0, 1, 0, 0, z);

    // Saturation then reset.
    step(1, 1, 0, 0, mk(2'b01, 2'b01, 32'h77));
    repeat (10) step(0, 0, 0, 0, z);
    check("sat_cnt", stall_cnt, CNT_MAX);
    step(0, 0, 0, 1, z);
    check("sat_rst", stall_cnt, 0);

    // Reset mid-stall with both entries full.
    step(1, 1, 0, 0, mk(2'b10, 2'b01, 32'h11));
    step(1, 0, 0, 0, mk(2'b10, 2'b10, 32'h22));
    step(1, 0, 0, 1, mk(2'b11, 2'b11, 32'h33));
    check("rst_valid", out_valid, 1'b0);
    check("rst_alu", alu_res_out, 32'h0);
    step(0, 1, 0, 0, z);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic v, o, f, r;
      v = ($urandom_range(0, 99) < 70);
      o = ($urandom_range(0, 99) < 60);
      f = ($urandom_range(0, 99) < 4);
      r = ($urandom_range(0, 99) < 2);
      step(v, o, f, r, rand_pl());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
